// File: rtl/cronometru_lap.sv
// -----------------------------------------------------------------------------
// cronometru_lap -- BCD stopwatch with lap hold and multiplexed 7-seg display.
//
// Optional feature macro: CRONOMETRU_LAP_HOLD_EN
//   defined   -> LAP state and lap register present (btn_lr in RUN freezes
//                the display on a captured count while counting continues)
//   undefined -> no LAP state, no lap register; btn_lr in RUN is ignored
//
// Parameters:
//   TICK_DIV  clk cycles per count increment (>= 2)
//   SCAN_DIV  clk cycles per display digit slot (>= 2)
//   DIGITS    number of BCD digits counted/displayed (2..8)
//   DP_POS    digit index whose decimal point is lit
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   btn_ss     start/stop request, single-cycle debounced pulse
//   btn_lr     lap/reset request, single-cycle debounced pulse
//   c[7:0]     active-low segments, c[6:0] = g..a, c[7] = dp (registered)
//   an         active-low one-hot digit enables (registered)
//   running    high in RUN and LAP
//   ovf        sticky flag, set when the count wraps from all 9s
//   dbg_state  current FSM state: 0 IDLE, 1 RUN, 2 STOP, 3 LAP
//
// Handshake: btn_ss/btn_lr carry no ready; every pulse is consumed in the
// cycle it is seen. If both arrive together, btn_ss wins and btn_lr is dropped.
// -----------------------------------------------------------------------------
module cronometru_lap #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 4,
  parameter int DP_POS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_ss,
  input  logic              btn_lr,
  output logic [7:0]        c,
  output logic [DIGITS-1:0] an,
  output logic              running,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

`ifdef CRONOMETRU_LAP_HOLD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, LAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
`endif

  state_t              state;
  logic [TW-1:0]       psc;
  logic [TW-1:0]       psc_nxt;
  logic [4*DIGITS-1:0] cnt;
  logic [4*DIGITS-1:0] cnt_inc;
`ifdef CRONOMETRU_LAP_HOLD_EN
  logic [4*DIGITS-1:0] lap;
`endif
  logic                carry;
  logic                tick;
  logic [SW-1:0]       spsc;
  logic [IW-1:0]       sidx;
  logic [4*DIGITS-1:0] disp;
  logic [3:0]          dig;
  logic [6:0]          seg;

  assign dbg_state = state;

  // BCD ripple increment; carry left set after the loop means every digit
  // was 9, i.e. the count wraps to all zeros.
  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign psc_nxt = (psc == TW'(TICK_DIV - 1)) ? '0 : psc + 1'b1;
  // running is high exactly in the counting states, so it gates the prescaler.
  assign tick    = running && (psc == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      cnt     <= '0;
      psc     <= '0;
      ovf     <= 1'b0;
`ifdef CRONOMETRU_LAP_HOLD_EN
      lap     <= '0;
`endif
    end else begin
      if (tick) begin
        cnt <= cnt_inc;
        if (carry) ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          psc <= '0;
          if (btn_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          psc <= psc_nxt;
          if (btn_ss) begin
            state   <= STOP;
            running <= 1'b0;
          end
`ifdef CRONOMETRU_LAP_HOLD_EN
          else if (btn_lr) begin
            state <= LAP;
            lap   <= cnt;
          end
`endif
        end
        STOP: begin
          // prescaler holds so a resume finishes the interrupted period
          if (btn_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (btn_lr) begin
            state <= IDLE;
            cnt   <= '0;
            psc   <= '0;
            ovf   <= 1'b0;
          end
        end
`ifdef CRONOMETRU_LAP_HOLD_EN
        LAP: begin
          psc <= psc_nxt;
          if (btn_ss) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (btn_lr) begin
            state <= RUN;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Digit selection and active-low segment decode (g..a).
  always_comb begin
    disp = cnt;
`ifdef CRONOMETRU_LAP_HOLD_EN
    if (state == LAP) disp = lap;
`endif
    dig = disp[{sidx, 2'b00} +: 4];
    case (dig)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

  // Scan runs in every state; pins are registered one cycle behind sidx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spsc <= '0;
      sidx <= '0;
      c    <= 8'hFF;
      an   <= '1;
    end else begin
      if (spsc == SW'(SCAN_DIV - 1)) begin
        spsc <= '0;
        sidx <= (sidx == IW'(DIGITS - 1)) ? '0 : sidx + 1'b1;
      end else begin
        spsc <= spsc + 1'b1;
      end
      an <= ~(DIGITS'(1) << sidx);
      c  <= {(int'(sidx) != DP_POS), seg};
    end
  end

endmodule

// File: tb/tb_cronometru_lap.sv
`timescale 1ns/1ps
module tb_cronometru_lap;
  localparam int TD   = 4;
  localparam int SD   = 3;
  localparam int ND   = 4;
  localparam int DP   = 2;
  localparam int MAXC = 10000;
`ifdef CRONOMETRU_LAP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_LAP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_ss = 1'b0;
  logic btn_lr = 1'b0;
  logic [7:0]    c;
  logic [ND-1:0] an;
  logic          running;
  logic          ovf;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  cronometru_lap #(.TICK_DIV(TD), .SCAN_DIV(SD), .DIGITS(ND), .DP_POS(DP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .c(c), .an(an), .running(running), .ovf(ovf), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Count kept as a plain integer 0..MAXC-1; display derived by decimal math.
  int            m_state, m_cnt, m_psc, m_lap, m_edges;
  bit            m_ovf;
  logic [7:0]    m_c;
  logic [ND-1:0] m_an;
  logic [ND-1:0] exp_q[$];

  function automatic logic [4*ND-1:0] bcd(input int v);
    logic [4*ND-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
      5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; 9: on = 7'h6F;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n  = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_state = S_IDLE; m_cnt = 0; m_psc = 0; m_lap = 0; m_ovf = 1'b0; m_edges = 0;
    m_c = 8'hFF; m_an = '1;
  endtask

  task automatic step(input bit ss, input bit lr);
    int slot, src, d, p, pre;
    bit run_m, tick;
    btn_ss = ss;
    btn_lr = lr;
    slot = (m_edges / SD) % ND;
    src  = (m_state == S_LAP) ? m_lap : m_cnt;
    p = 1;
    for (int i = 0; i < slot; i++) p = p * 10;
    d = (src / p) % 10;
    m_an = '1;
    m_an[slot] = 1'b0;
    m_c = {(slot != DP), seg_of(d)};
    run_m = (m_state == S_RUN) || (m_state == S_LAP);
    tick  = run_m && (m_psc == TD - 1);
    pre   = m_cnt;
    if (run_m) m_psc = (m_psc + 1) % TD;
    else if (m_state == S_IDLE) m_psc = 0;
    if (tick) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == MAXC) begin m_cnt = 0; m_ovf = 1'b1; end
    end
    case (m_state)
      S_IDLE: if (ss) m_state = S_RUN;
      S_RUN:  if (ss) m_state = S_STOP;
              else if (lr && HOLD) begin m_state = S_LAP; m_lap = pre; end
      S_STOP: if (ss) m_state = S_RUN;
              else if (lr) begin m_state = S_IDLE; m_cnt = 0; m_psc = 0; m_ovf = 1'b0; end
      S_LAP:  if (ss) m_state = S_STOP;
              else if (lr) m_state = S_RUN;
      default: m_state = S_IDLE;
    endcase
    m_edges++;
    @(posedge clk);
    #1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++; if (c !== 8'hFF) begin fails++; $display("FAIL reset_c: got %h want ff", c); end
    tests++; if (an !== 4'hF) begin fails++; $display("FAIL reset_an: got %b want 1111", an); end
    tests++; if (running !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL reset_flags: got run=%b ovf=%b want 0 0", running, ovf); end
    tests++; if (dbg_state !== 2'(S_IDLE) || dut.cnt !== 16'h0000) begin fails++; $display("FAIL reset_state: got st=%0d cnt=%h want 0 0000", dbg_state, dut.cnt); end
    rst_n = 1'b1;
    step(1, 0);
    repeat (9) step(0, 0);
    do_reset();
    tests++; if (running !== 1'b0 || dbg_state !== 2'(S_IDLE) || dut.cnt !== 16'h0000 || an !== 4'hF) begin
      fails++; $display("FAIL reset_override: got run=%b st=%0d cnt=%h an=%b want 0 0 0000 1111", running, dbg_state, dut.cnt, an);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    do_reset();
    rst_n = 1'b1;
    step(1, 0);
    tests++; if (running !== 1'b1 || dbg_state !== 2'(S_RUN)) begin fails++; $display("FAIL start_running: got run=%b st=%0d want 1 1", running, dbg_state); end
    for (int k = 1; k <= 12; k++) begin
      step(0, 0);
      tests++; if (dut.cnt !== bcd(m_cnt)) begin fails++; $display("FAIL start_cnt_c%0d: got %h want %h", k, dut.cnt, bcd(m_cnt)); end
      if (k == 3) begin tests++; if (dut.cnt !== 16'h0000) begin fails++; $display("FAIL start_c3: got %h want 0000", dut.cnt); end end
      if (k == 4) begin tests++; if (dut.cnt !== 16'h0001) begin fails++; $display("FAIL start_c4: got %h want 0001", dut.cnt); end end
      if (k == 12) begin tests++; if (dut.cnt !== 16'h0003) begin fails++; $display("FAIL start_c12: got %h want 0003", dut.cnt); end end
    end
  endtask

  task automatic test_stop_resume();
    int n;
    n = 0;
    while (m_cnt != 5 && n < 200) begin step(0, 0); n++; end
    tests++; if (dut.cnt !== 16'h0005) begin fails++; $display("FAIL sr_reach5: got %h want 0005", dut.cnt); end
    step(0, 0);
    step(0, 0);
    step(1, 0);
    tests++; if (dbg_state !== 2'(S_STOP) || running !== 1'b0) begin fails++; $display("FAIL sr_stop: got st=%0d run=%b want 2 0", dbg_state, running); end
    for (int k = 0; k < 20; k++) begin
      step(0, 0);
      tests++; if (dut.cnt !== 16'h0005) begin fails++; $display("FAIL sr_hold_%0d: got %h want 0005", k, dut.cnt); end
    end
    step(1, 0);
    tests++; if (dut.cnt !== 16'h0005 || running !== 1'b1) begin fails++; $display("FAIL sr_resume: got cnt=%h run=%b want 0005 1", dut.cnt, running); end
    step(0, 0);
    tests++; if (dut.cnt !== 16'h0006) begin fails++; $display("FAIL sr_partial_period: got %h want 0006", dut.cnt); end
    step(1, 0);
    step(0, 1);
    tests++; if (dut.cnt !== 16'h0000 || dbg_state !== 2'(S_IDLE) || ovf !== 1'b0) begin
      fails++; $display("FAIL sr_clear: got cnt=%h st=%0d ovf=%b want 0000 0 0", dut.cnt, dbg_state, ovf);
    end
    step(1, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0);
      tests++; if (dut.cnt !== bcd(m_cnt)) begin fails++; $display("FAIL sr_full_period_%0d: got %h want %h", k, dut.cnt, bcd(m_cnt)); end
    end
  endtask

  task automatic test_lap();
    int n;
    do_reset();
    rst_n = 1'b1;
    step(1, 0);
    n = 0;
    while (m_cnt != 7 && n < 200) begin step(0, 0); n++; end
    step(0, 1);
`ifdef CRONOMETRU_LAP_HOLD_EN
    tests++; if (dbg_state !== 2'(S_LAP) || running !== 1'b1 || dut.lap !== 16'h0007) begin
      fails++; $display("FAIL lap_enter: got st=%0d run=%b lap=%h want 3 1 0007", dbg_state, running, dut.lap);
    end
    n = 0;
    while (m_cnt != 12 && n < 200) begin
      step(0, 0);
      n++;
      tests++; if (c !== m_c || an !== m_an) begin fails++; $display("FAIL lap_display: got c=%h an=%b want c=%h an=%b", c, an, m_c, m_an); end
      if (an[1] == 1'b0) begin tests++; if (c[6:0] !== seg_of(0)) begin fails++; $display("FAIL lap_frozen_d1: got %h want %h", c[6:0], seg_of(0)); end end
    end
    tests++; if (dut.cnt !== 16'h0012) begin fails++; $display("FAIL lap_internal: got %h want 0012", dut.cnt); end
    step(0, 1);
    tests++; if (dbg_state !== 2'(S_RUN)) begin fails++; $display("FAIL lap_exit: got st=%0d want 1", dbg_state); end
    for (int k = 1; k <= 13; k++) begin
      step(0, 0);
      tests++; if (c !== m_c || an !== m_an) begin fails++; $display("FAIL lap_live: got c=%h an=%b want c=%h an=%b", c, an, m_c, m_an); end
      if (an[1] == 1'b0) begin tests++; if (c[6:0] !== seg_of(1)) begin fails++; $display("FAIL lap_live_d1: got %h want %h", c[6:0], seg_of(1)); end end
    end
`else
    tests++; if (dbg_state !== 2'(S_RUN) || running !== 1'b1) begin fails++; $display("FAIL lr_ignored: got st=%0d run=%b want 1 1", dbg_state, running); end
    repeat (4) step(0, 0);
    tests++; if (dut.cnt !== 16'h0008) begin fails++; $display("FAIL lr_counting: got %h want 0008", dut.cnt); end
`endif
  endtask

  task automatic test_both();
    int n;
    do_reset();
    rst_n = 1'b1;
    step(1, 0);
    n = 0;
    while (m_cnt != 3 && n < 200) begin step(0, 0); n++; end
    step(1, 1);
    tests++; if (dbg_state !== 2'(S_STOP) || running !== 1'b0) begin fails++; $display("FAIL both_stop: got st=%0d run=%b want 2 0", dbg_state, running); end
`ifdef CRONOMETRU_LAP_HOLD_EN
    tests++; if (dut.lap !== 16'h0000) begin fails++; $display("FAIL both_nolap: got %h want 0000", dut.lap); end
`endif
    repeat (8) step(0, 0);
    tests++; if (dut.cnt !== 16'h0003) begin fails++; $display("FAIL both_hold: got %h want 0003", dut.cnt); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    rst_n = 1'b1;
    step(1, 0);
    n = 0;
    while (m_cnt != 9998 && n < 45000) begin step(0, 0); n++; end
    tests++; if (dut.cnt !== 16'h9998 || ovf !== 1'b0) begin fails++; $display("FAIL wrap_9998: got cnt=%h ovf=%b want 9998 0", dut.cnt, ovf); end
    repeat (4) step(0, 0);
    tests++; if (dut.cnt !== 16'h9999 || ovf !== 1'b0) begin fails++; $display("FAIL wrap_9999: got cnt=%h ovf=%b want 9999 0", dut.cnt, ovf); end
    repeat (4) step(0, 0);
    tests++; if (dut.cnt !== 16'h0000 || ovf !== 1'b1) begin fails++; $display("FAIL wrap_0000: got cnt=%h ovf=%b want 0000 1", dut.cnt, ovf); end
    for (int k = 0; k < 20; k++) begin
      step(0, 0);
      tests++; if (ovf !== 1'b1 || dut.cnt !== bcd(m_cnt)) begin fails++; $display("FAIL wrap_sticky_%0d: got ovf=%b cnt=%h want 1 %h", k, ovf, dut.cnt, bcd(m_cnt)); end
    end
    step(1, 0);
    repeat (5) step(0, 0);
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL wrap_stop_ovf: got %b want 1", ovf); end
    step(0, 1);
    tests++; if (ovf !== 1'b0 || dut.cnt !== 16'h0000) begin fails++; $display("FAIL wrap_clear: got ovf=%b cnt=%h want 0 0000", ovf, dut.cnt); end
  endtask

  task automatic test_scan();
    logic [3:0] tab [4];
    logic [3:0] e;
    tab[0] = 4'b1110; tab[1] = 4'b1101; tab[2] = 4'b1011; tab[3] = 4'b0111;
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) exp_q.push_back(tab[k / 3]);
    for (int k = 0; k < 12; k++) begin
      step(0, 0);
      e = exp_q.pop_front();
      tests++; if (an !== e) begin fails++; $display("FAIL scan_an_%0d: got %b want %b", k, an, e); end
      tests++; if (c[7] !== ((k / 3) != 2)) begin fails++; $display("FAIL scan_dp_%0d: got %b want %b", k, c[7], ((k / 3) != 2)); end
      tests++; if (c[6:0] !== seg_of(0)) begin fails++; $display("FAIL scan_seg_%0d: got %h want %h", k, c[6:0], seg_of(0)); end
    end
    repeat (4) step(0, 0);
    do_reset();
    tests++; if (an !== 4'hF || c !== 8'hFF) begin fails++; $display("FAIL scan_reset: got an=%b c=%h want 1111 ff", an, c); end
    rst_n = 1'b1;
    step(0, 0);
    tests++; if (an !== 4'b1110) begin fails++; $display("FAIL scan_first_slot: got %b want 1110", an); end
  endtask

  task automatic test_random();
    bit ss, lr;
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        rst_n = 1'b1;
      end
      ss = ($urandom_range(0, 9) == 0);
      lr = ($urandom_range(0, 7) == 0);
      step(ss, lr);
      tests++;
      if (dbg_state !== 2'(m_state) || running !== ((m_state == S_RUN) || (m_state == S_LAP)) ||
          ovf !== m_ovf || dut.cnt !== bcd(m_cnt) || c !== m_c || an !== m_an) begin
        fails++;
        $display("FAIL random_%0d: got st=%0d run=%b ovf=%b cnt=%h c=%h an=%b want st=%0d ovf=%b cnt=%h c=%h an=%b",
                 k, dbg_state, running, ovf, dut.cnt, c, an, m_state, m_ovf, bcd(m_cnt), m_c, m_an);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_start();
    test_stop_resume();
    test_lap();
    test_both();
    test_scan();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cronometru_lap.md
CRONOMETRU_LAP -- requirements
Module: cronometru_lap

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000: clk cycles per count increment (100 Hz at 50 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per display digit slot; legal values are 2 and above.
REQ-003 SHALL have parameter DIGITS, default 4: number of BCD digits counted and displayed; legal range 2..8.
REQ-004 SHALL have parameter DP_POS, default 2: digit index whose decimal point is lit.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-007 SHALL have port btn_ss, input, 1 bit: start/stop request, single-cycle pulse, already debounced.
REQ-008 SHALL have port btn_lr, input, 1 bit: lap/reset request, single-cycle pulse, already debounced.
REQ-009 SHALL have port c, output, 8 bits: active-low segments; c[6:0] = g..a, c[7] = dp.
REQ-010 SHALL have port an, output, DIGITS bits: active-low one-hot digit enables.
REQ-011 SHALL have port running, output, 1 bit: high in RUN and LAP.
REQ-012 SHALL have port ovf, output, 1 bit: sticky count wrap flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP and LAP.
REQ-014 SHALL take these transitions on btn_ss: IDLE->RUN; RUN->STOP; STOP->RUN; LAP->STOP.
REQ-015 SHALL take these transitions on btn_lr: RUN->LAP; LAP->RUN; STOP->IDLE; IDLE stays IDLE.
REQ-016 SHALL, when btn_ss and btn_lr are high in the same cycle, act on btn_ss only and ignore btn_lr.
REQ-017 SHALL hold the count as DIGITS BCD digits, digit 0 least significant, each digit 0..9 carrying into the next.
REQ-018 SHALL run the prescaler 0..TICK_DIV-1 only in RUN and LAP; it holds its value in STOP and is cleared in IDLE.
REQ-019 SHALL increment the count by one in the cycle the prescaler equals TICK_DIV-1; the first increment occurs TICK_DIV cycles after the accepted start pulse.
REQ-020 SHALL, when the count is all 9s at an increment, wrap it to all 0s, set ovf, and keep counting.
REQ-021 SHALL, on the STOP->IDLE transition, clear the count, prescaler and ovf in the next cycle.
REQ-022 SHALL, on entry to LAP, copy the current count into a lap register; LAP displays the lap register while counting continues.
REQ-023 SHALL display the live count in all other states.
REQ-024 SHALL advance the scan index 0..DIGITS-1 every SCAN_DIV cycles, wrapping to 0, in all states.
REQ-025 SHALL drive an[i] low only while the scan index equals i.
REQ-026 SHALL drive c with the active-low 7-segment pattern of the selected digit; digits 0..9 use the standard patterns.
REQ-027 SHALL drive c[7] low only while the scan index equals DP_POS.
REQ-028 SHALL register c and an, giving one cycle of latency from scan index to pins.

Reset
REQ-029 SHALL, while rst_n is low at a clk edge, enter IDLE and clear the count, lap register, prescaler and scan index.
REQ-030 SHALL, while rst_n is low, drive c=8'hFF, an all ones, running=0 and ovf=0.
REQ-031 SHALL override any in-progress run or lap when reset is asserted; the first scan slot after reset release is digit 0.

Configuration
REQ-032 SHALL, with macro CRONOMETRU_LAP_HOLD_EN defined, implement the LAP state and lap register as specified.
REQ-033 SHALL, with CRONOMETRU_LAP_HOLD_EN undefined, omit the LAP state and lap register; btn_lr in RUN is ignored and all other behaviour is unchanged.

Verification (TICK_DIV=4, SCAN_DIV=3, DIGITS=4, DP_POS=2 unless stated)
REQ-034 SHALL cover: reset, then btn_ss pulse at cycle 0 -> running=1 next cycle; count=0001 at cycle 4 and 0003 at cycle 12.
REQ-035 SHALL cover: run to 0005, then btn_ss -> count holds 0005 for 20 cycles; btn_ss again -> next increment after the remaining prescaler cycles, not after a full period; then btn_ss and btn_lr -> count=0000.
REQ-036 SHALL cover: with HOLD_EN, btn_lr at count 0007 -> display shows 0007 while the internal count reaches 0012; btn_lr again -> display goes live.
REQ-037 SHALL cover: preload the count at 9998 (DIGITS=4), run 2 ticks -> count=0000 and ovf=1; ovf stays 1 until STOP->IDLE.
REQ-038 SHALL cover: btn_ss and btn_lr in the same cycle while in RUN -> state becomes STOP with no lap captured.
REQ-039 SHALL cover: scan check -> an sequence 1110, 1101, 1011, 0111, each slot 3 cycles; c[7]=0 only while an=1011; rst_n low mid-scan -> an=1111.
